// File: rtl/multicycle_computer_pkg.sv
// ============================================================
// Module  : multicycle_computer_pkg
// Summary : Shared encodings for the multicycle computer controller
// Rev     : 1.0
// ============================================================
`default_nettype none

package multicycle_computer_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECUTER = 4'd7,
        EXECUTEI = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10
`ifdef MC_CTRL_BL_EN
        ,BL_LINK = 4'd11
`endif
    } state_t;

    localparam logic [3:0] c_cond_eq = 4'b0000;
    localparam logic [3:0] c_cond_ne = 4'b0001;
    localparam logic [3:0] c_cond_cs = 4'b0010;
    localparam logic [3:0] c_cond_cc = 4'b0011;
    localparam logic [3:0] c_cond_mi = 4'b0100;
    localparam logic [3:0] c_cond_pl = 4'b0101;
    localparam logic [3:0] c_cond_vs = 4'b0110;
    localparam logic [3:0] c_cond_vc = 4'b0111;
    localparam logic [3:0] c_cond_hi = 4'b1000;
    localparam logic [3:0] c_cond_ls = 4'b1001;
    localparam logic [3:0] c_cond_ge = 4'b1010;
    localparam logic [3:0] c_cond_lt = 4'b1011;
    localparam logic [3:0] c_cond_gt = 4'b1100;
    localparam logic [3:0] c_cond_le = 4'b1101;
    localparam logic [3:0] c_cond_al = 4'b1110;

    localparam logic [1:0] c_op_dp  = 2'b00;
    localparam logic [1:0] c_op_mem = 2'b01;
    localparam logic [1:0] c_op_br  = 2'b10;
    localparam logic [1:0] c_op_nop = 2'b11;

    localparam logic [3:0] c_cmd_and = 4'b0000;
    localparam logic [3:0] c_cmd_sub = 4'b0010;
    localparam logic [3:0] c_cmd_add = 4'b0100;
    localparam logic [3:0] c_cmd_cmp = 4'b1010;
    localparam logic [3:0] c_cmd_orr = 4'b1100;
    localparam logic [3:0] c_cmd_mov = 4'b1101;

    localparam logic [2:0] c_aluop_none = 3'b000;
    localparam logic [2:0] c_aluop_sub  = 3'b010;
    localparam logic [2:0] c_aluop_and  = 3'b011;
    localparam logic [2:0] c_aluop_orr  = 3'b100;
    localparam logic [2:0] c_aluop_add  = 3'b101;
    localparam logic [2:0] c_aluop_mov  = 3'b110;

    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_rd1   = 2'b01;
    localparam logic [1:0] c_srca_br    = 2'b10;
    localparam logic [1:0] c_srcb_reg   = 2'b00;
    localparam logic [1:0] c_srcb_imm   = 2'b01;
    localparam logic [1:0] c_srcb_br    = 2'b10;
    localparam logic [1:0] c_srcb_four  = 2'b11;
    localparam logic [1:0] c_res_alu    = 2'b00;
    localparam logic [1:0] c_res_mem    = 2'b01;
    localparam logic [1:0] c_res_aluout = 2'b10;
    localparam logic [1:0] c_regsrc_dflt = 2'b10;
    localparam logic [2:0] c_shift_none = 3'b111;

    function automatic logic [2:0] alu_op_map(input logic [3:0] cmd);
        case (cmd)
            c_cmd_add: alu_op_map = c_aluop_add;
            c_cmd_sub: alu_op_map = c_aluop_sub;
            c_cmd_and: alu_op_map = c_aluop_and;
            c_cmd_orr: alu_op_map = c_aluop_orr;
            c_cmd_mov: alu_op_map = c_aluop_mov;
            c_cmd_cmp: alu_op_map = c_aluop_sub;
            default:   alu_op_map = c_aluop_add;
        endcase
    endfunction

    // Unknown commands still run through the ALU but must not commit a result.
    function automatic logic cmd_writes_reg(input logic [3:0] cmd);
        case (cmd)
            c_cmd_add, c_cmd_sub, c_cmd_and, c_cmd_orr, c_cmd_mov: cmd_writes_reg = 1'b1;
            default: cmd_writes_reg = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_computer_controller_cond_check.sv
// ============================================================
// Module  : cond_check
// Summary : Combinational condition-code evaluation against NZCV
// Rev     : 1.0
// ============================================================
`default_nettype none

module cond_check
    import multicycle_computer_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign {w_n, w_z, w_c, w_v} = i_flags;

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            c_cond_eq: o_pass = w_z;
            c_cond_ne: o_pass = !w_z;
            c_cond_cs: o_pass = w_c;
            c_cond_cc: o_pass = !w_c;
            c_cond_mi: o_pass = w_n;
            c_cond_pl: o_pass = !w_n;
            c_cond_vs: o_pass = w_v;
            c_cond_vc: o_pass = !w_v;
            c_cond_hi: o_pass = w_c && !w_z;
            c_cond_ls: o_pass = !w_c || w_z;
            c_cond_ge: o_pass = (w_n == w_v);
            c_cond_lt: o_pass = (w_n != w_v);
            c_cond_gt: o_pass = !w_z && (w_n == w_v);
            c_cond_le: o_pass = w_z || (w_n != w_v);
            c_cond_al: o_pass = 1'b1;
            default:   o_pass = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_computer_controller.sv
// ============================================================
// Module  : multicycle_computer_controller
// Summary : Moore control FSM for the multicycle datapath;
//           BL link state built only with MC_CTRL_BL_EN defined
// Rev     : 1.0
// ============================================================
`default_nettype none

module multicycle_computer_controller
    import multicycle_computer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] INSTRUCTION_OUT,
    input  logic [3:0]  FLAGS,
    output logic        A3Src,
    output logic        AdrSrc,
    output logic        FlagUpdate,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        WD3Src,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUop,
    output logic [2:0]  ShiftType,
    output logic [3:0]  state_out
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_funct;
    logic [3:0] r_rd;
    logic       w_pass;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_cmd;
    logic       w_unused;

    assign w_op     = INSTRUCTION_OUT[27:26];
    assign w_funct  = INSTRUCTION_OUT[25:20];
    assign w_cmd    = r_funct[4:1];
    assign w_unused = ^{INSTRUCTION_OUT[19:16], INSTRUCTION_OUT[11:0], r_funct[5]};
    assign state_out = r_state;

    cond_check u_cond_check (
        .i_cond  (INSTRUCTION_OUT[31:28]),
        .i_flags (FLAGS),
        .o_pass  (w_pass)
    );

    // IR fields are frozen on leaving DECODE so later states ignore IR/bus changes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_RESET;
            r_funct <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_funct <= w_funct;
                r_rd    <= INSTRUCTION_OUT[15:12];
            end
        end
    end

    always_comb begin
        w_next     = FETCH;
        A3Src      = 1'b0;
        AdrSrc     = 1'b0;
        FlagUpdate = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        WD3Src     = 1'b0;
        ALUSrcA    = c_srca_pc;
        ALUSrcB    = c_srcb_reg;
        ResultSrc  = c_res_alu;
        RegSrc     = c_regsrc_dflt;
        ALUop      = c_aluop_none;
        ShiftType  = c_shift_none;
        case (r_state)
            S_RESET: begin
                RegSrc = 2'b00;
                w_next = FETCH;
            end
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = c_srcb_four;
                ResultSrc = c_res_aluout;
                w_next    = DECODE;
            end
            DECODE: begin
                ResultSrc = c_res_aluout;
                RegSrc    = {w_op == c_op_mem, w_op == c_op_br};
                if (!w_pass) begin
                    w_next = FETCH;
                end else begin
                    case (w_op)
                        c_op_mem: w_next = MEMADR;
                        c_op_dp:  w_next = w_funct[5] ? EXECUTEI : EXECUTER;
                        c_op_br:  w_next = BRANCH;
                        c_op_nop: w_next = FETCH;
                        default:  w_next = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                ALUSrcA = c_srca_rd1;
                ALUSrcB = c_srcb_imm;
                w_next  = r_funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = MEMWB;
            end
            MEMWB: begin
                AdrSrc    = 1'b1;
                RegWrite  = 1'b1;
                ResultSrc = c_res_mem;
                w_next    = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                w_next   = FETCH;
            end
            EXECUTER, EXECUTEI: begin
                ALUSrcA    = c_srca_rd1;
                ALUSrcB    = (r_state == EXECUTEI) ? c_srcb_imm : c_srcb_reg;
                ALUop      = alu_op_map(w_cmd);
                FlagUpdate = r_funct[0] || (w_cmd == c_cmd_cmp);
                w_next     = (w_cmd == c_cmd_cmp) ? FETCH : ALUWB;
            end
            ALUWB: begin
                ResultSrc = c_res_alu;
                PCWrite   = (r_rd == 4'd15);
                RegWrite  = (r_rd != 4'd15) && cmd_writes_reg(w_cmd);
                w_next    = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = c_srca_br;
                ALUSrcB   = c_srcb_br;
                ResultSrc = c_res_aluout;
                PCWrite   = 1'b1;
`ifdef MC_CTRL_BL_EN
                w_next    = r_funct[4] ? BL_LINK : FETCH;
`else
                w_next    = FETCH;
`endif
            end
`ifdef MC_CTRL_BL_EN
            BL_LINK: begin
                A3Src    = 1'b1;
                WD3Src   = 1'b1;
                RegWrite = 1'b1;
                w_next   = FETCH;
            end
`endif
            default: w_next = FETCH;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_computer_controller.sv
// ============================================================
// Module  : tb_multicycle_computer_controller
// Summary : Self-checking bench; honours MC_CTRL_BL_EN when defined
// Rev     : 1.0
// ============================================================
`default_nettype none

module tb_multicycle_computer_controller;
    import multicycle_computer_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] INSTRUCTION_OUT;
    logic [3:0]  FLAGS;
    logic        A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, RegSrc;
    logic [2:0]  ALUop, ShiftType;
    logic [3:0]  state_out;

    multicycle_computer_controller dut (
        .clock(clock), .reset(reset), .INSTRUCTION_OUT(INSTRUCTION_OUT), .FLAGS(FLAGS),
        .A3Src(A3Src), .AdrSrc(AdrSrc), .FlagUpdate(FlagUpdate), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .WD3Src(WD3Src),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .RegSrc(RegSrc),
        .ALUop(ALUop), .ShiftType(ShiftType), .state_out(state_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [7:0] E_A3  = 8'h80, E_ADR = 8'h40, E_FU = 8'h20, E_IR  = 8'h10;
    localparam logic [7:0] E_MW  = 8'h08, E_PC  = 8'h04, E_RW = 8'h02, E_WD3 = 8'h01;
`ifdef MC_CTRL_BL_EN
    localparam int BL_CYC = 4;
`else
    localparam int BL_CYC = 3;
`endif

    typedef struct {
        state_t     st;
        logic [7:0] en;
        logic [1:0] srca, srcb, res, regsrc;
        logic [2:0] aluop;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  flags;
        int          cycles;
    } vec_t;

    exp_t model_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t rec(input state_t s, input logic [7:0] en, input logic [1:0] a,
                                 input logic [1:0] b, input logic [1:0] r, input logic [1:0] rs,
                                 input logic [2:0] op);
        exp_t e;
        e.st = s; e.en = en; e.srca = a; e.srcb = b; e.res = r; e.regsrc = rs; e.aluop = op;
        return e;
    endfunction

    // Even codes test a flag predicate, odd codes invert it.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        {n, z, cy, v} = f;
        if (c == 4'b1110) return 1'b1;
        if (c == 4'b1111) return 1'b0;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            default: r = !z && (n == v);
        endcase
        return c[0] ? !r : r;
    endfunction

    task automatic build(input logic [31:0] ins, input logic [3:0] fl);
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] cmd;
        logic [2:0] aop;
        bit         known;
        state_t     ex;
        logic [7:0] wb;
        op  = ins[27:26];
        fn  = ins[25:20];
        cmd = fn[4:1];
        model_q.delete();
        model_q.push_back(rec(FETCH, E_IR | E_PC, 2'b00, 2'b11, 2'b10, 2'b10, 3'b000));
        model_q.push_back(rec(DECODE, 8'h00, 2'b00, 2'b00, 2'b10, {op == 2'b01, op == 2'b10}, 3'b000));
        if (!cond_ok(ins[31:28], fl) || op == 2'b11) return;
        if (op == 2'b01) begin
            model_q.push_back(rec(MEMADR, 8'h00, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000));
            if (fn[0]) begin
                model_q.push_back(rec(MEMREAD, E_ADR, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000));
                model_q.push_back(rec(MEMWB, E_ADR | E_RW, 2'b00, 2'b00, 2'b01, 2'b10, 3'b000));
            end else begin
                model_q.push_back(rec(MEMWRITE, E_ADR | E_MW, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000));
            end
        end else if (op == 2'b00) begin
            known = 1'b1;
            case (cmd)
                4'b0100: aop = 3'b101;
                4'b0010: aop = 3'b010;
                4'b0000: aop = 3'b011;
                4'b1100: aop = 3'b100;
                4'b1101: aop = 3'b110;
                4'b1010: aop = 3'b010;
                default: begin aop = 3'b101; known = 1'b0; end
            endcase
            if (fn[5]) ex = EXECUTEI; else ex = EXECUTER;
            model_q.push_back(rec(ex, (fn[0] || cmd == 4'b1010) ? E_FU : 8'h00, 2'b01,
                                  fn[5] ? 2'b01 : 2'b00, 2'b00, 2'b10, aop));
            if (cmd != 4'b1010) begin
                if (ins[15:12] == 4'hF) wb = E_PC;
                else wb = known ? E_RW : 8'h00;
                model_q.push_back(rec(ALUWB, wb, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000));
            end
        end else begin
            model_q.push_back(rec(BRANCH, E_PC, 2'b10, 2'b10, 2'b10, 2'b10, 3'b000));
`ifdef MC_CTRL_BL_EN
            if (fn[4]) model_q.push_back(rec(BL_LINK, E_A3 | E_WD3 | E_RW, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000));
`endif
        end
    endtask

    task automatic check(input string nm, input exp_t e);
        logic [25:0] act, want;
        act  = {state_out, A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
                ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType};
        want = {4'(e.st), e.en, e.srca, e.srcb, e.res, e.regsrc, e.aluop, 3'b111};
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s state=%0d: got %h expected %h", nm, e.st, act, want);
        end
    endtask

    // Entered and left at a falling edge where the DUT sits in FETCH.
    task automatic run_instr(input string nm, input logic [31:0] ins, input logic [3:0] fl, input int cycles);
        int cnt;
        build(ins, fl);
        INSTRUCTION_OUT = ins;
        FLAGS           = fl;
        for (int i = 0; i < model_q.size(); i++) begin
            if (i > 0) @(negedge clock);
            check(nm, model_q[i]);
            if (i > 1) begin
                INSTRUCTION_OUT = $urandom;
                FLAGS           = 4'($urandom);
                #1 check({nm, "_hold"}, model_q[i]);
            end
        end
        cnt = model_q.size();
        @(negedge clock);
        while (state_out !== 4'(FETCH) && cnt < 12) begin
            @(negedge clock);
            cnt++;
        end
        n_vec++;
        if (cnt != ((cycles < 0) ? model_q.size() : cycles)) begin
            n_err++;
            $display("FAIL %s_cycles: got %0d expected %0d", nm, cnt,
                     (cycles < 0) ? model_q.size() : cycles);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[$];
        logic [3:0]  cmds [8];
        logic [31:0] ins;

        tbl.push_back('{"ldr",     32'hE5911040, 4'h0, 5});
        tbl.push_back('{"add",     32'hE0810002, 4'h0, 4});
        tbl.push_back('{"addeq_f", 32'h00810002, 4'h0, 2});
        tbl.push_back('{"addeq_t", 32'h00810002, 4'h4, 4});
        tbl.push_back('{"str",     32'hE5802008, 4'h0, 4});
        tbl.push_back('{"b",       32'hEA000002, 4'h0, 3});
        tbl.push_back('{"bl",      32'hEB000002, 4'h0, BL_CYC});
        tbl.push_back('{"cmp",     32'hE3510005, 4'h0, 3});
        tbl.push_back('{"mov_pc",  32'hE1A0F001, 4'h0, 4});
        tbl.push_back('{"subs",    32'hE0510002, 4'h0, 4});
        tbl.push_back('{"orr",     32'hE1810002, 4'h0, 4});
        tbl.push_back('{"eor_unk", 32'hE0210002, 4'h0, 4});
        tbl.push_back('{"op11",    32'hEC000000, 4'h0, 2});
        tbl.push_back('{"cond_nv", 32'hF0810002, 4'hF, 2});
        tbl.push_back('{"addne_f", 32'h10810002, 4'h4, 2});
        tbl.push_back('{"addgt_t", 32'hC0810002, 4'h9, 4});
        tbl.push_back('{"addlt_f", 32'hB0810002, 4'h9, 2});

        reset           = 1'b0;
        INSTRUCTION_OUT = $urandom;
        FLAGS           = 4'($urandom);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset", rec(S_RESET, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        reset = 1'b1;
        @(negedge clock);

        foreach (tbl[i]) run_instr(tbl[i].name, tbl[i].instr, tbl[i].flags, tbl[i].cycles);

        // Reset pulled mid-LDR, while in MEMREAD.
        build(32'hE5911040, 4'h0);
        INSTRUCTION_OUT = 32'hE5911040;
        FLAGS           = 4'h0;
        check("rst_mid_fetch", model_q[0]);
        repeat (3) @(negedge clock);
        check("rst_mid_memread", model_q[3]);
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_sreset", rec(S_RESET, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_refetch", rec(FETCH, E_IR | E_PC, 2'b00, 2'b11, 2'b10, 2'b10, 3'b000));

        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101, 4'b1010, 4'b0001, 4'b1111};
        for (int k = 0; k < 200; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0) ins[31:28] = 4'hE;
            if (ins[27:26] == 2'b00 && $urandom_range(0, 3) != 0) ins[24:21] = cmds[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) ins[15:12] = 4'hF;
            run_instr("rand", ins, 4'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
